checkerboard_wr_arbiter: RTL

- Sequences the single write port of checkerboard_state_ram: 64 entries x 2-bit cell state; 1 write port, 2 async read ports.
- Shares that write port between two requesters (move-placement logic and capture-removal logic) with round-robin valid/ready arbitration.
- Owns a board-clear sequencer that sweeps every address writing EMPTY.
- Sits between game logic and the RAM; read ports are not touched.

---
 rtl/checkerboard_pkg.sv | 18 +
 rtl/checkerboard_rr_arb2.sv | 42 ++++
 rtl/checkerboard_wr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/checkerboard_pkg.sv
// Shared constants for the checkerboard board-state write path: FSM encoding,
// cell values and board geometry.
package checkerboard_pkg;

  localparam int BOARD_ADDR_W = 6;
  localparam int BOARD_DEPTH  = 64;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/checkerboard_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a tie
// and moves to the loser after every grant.
module checkerboard_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/checkerboard_wr_arbiter.sv
// Owns the board RAM write port: round-robin between two requesters plus a
// full-board clear sweep. CHECKERBOARD_CLEAR_ON_RESET_EN sweeps after reset.
module checkerboard_wr_arbiter
  import checkerboard_pkg::*;
#(
  parameter int              ADDR_W    = BOARD_ADDR_W,
  parameter int              DATA_W    = 2,
  parameter int              DEPTH     = BOARD_DEPTH,  // must be 2**ADDR_W
  parameter logic [DATA_W-1:0] EMPTY_VAL = DATA_W'(EMPTY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data
);

`ifdef CHECKERBOARD_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = ST_CLEAR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ram_wr_en_q, ram_wr_en_d;
  logic [ADDR_W-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;
  logic [1:0]        grant;
  logic              arb_en;

  // Clear entry and requester acceptance are mutually exclusive, so an
  // accepted write can never be interleaved with the sweep.
  assign arb_en = rst_n && (state_q == ST_IDLE) && !clear_req;

  checkerboard_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign clear_busy  = clear_busy_q;
  assign clear_done  = clear_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every RAM-facing output is registered: a handshake or sweep step in one
  // cycle appears on the write port in the next.
  always_comb begin
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    clear_busy_d  = 1'b0;
    clear_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant[0]) begin
          ram_wr_en_d   = 1'b1;
          ram_wr_addr_d = req0_addr;
          ram_wr_data_d = req0_data;
        end else if (grant[1]) begin
          ram_wr_en_d   = 1'b1;
          ram_wr_addr_d = req1_addr;
          ram_wr_data_d = req1_data;
        end
      end
      ST_CLEAR: begin
        ram_wr_en_d   = 1'b1;
        ram_wr_addr_d = cnt_q;
        ram_wr_data_d = EMPTY_VAL;
        clear_busy_d  = 1'b1;
      end
      ST_DONE: begin
        clear_done_d = 1'b1;
      end
      default: begin
        ram_wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      clear_busy_q  <= 1'b0;
      clear_done_q  <= 1'b0;
    end else begin
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      clear_busy_q  <= clear_busy_d;
      clear_done_q  <= clear_done_d;
    end
  end

endmodule
